fifo_frame_reader: RTL and testbench

//  Read-side consumer of the async FIFO. Runs in the rd_clk domain.
//  - Drains 16-bit words through the FIFO's empty / rd_en / data_out interface.
//  - Wraps every FRAME_LEN payload words into a frame: HEADER, payload, 16-bit additive checksum.
//  - Presents frames on a valid/ready stream to the downstream link.
//  - Pads a partial frame with PAD_WORD when the FIFO stays empty for TIMEOUT cycles.

---
 rtl/fifo_pkg.sv | 33 +++
 rtl/stream_out_reg.sv | 52 +++++
 rtl/fifo_frame_reader.sv | 173 +++++++++++++++++
 tb/tb_fifo_frame_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_pkg
// Description : Shared widths, default frame words and FSM state codes for
//               the FIFO frame reader.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Word width of the FIFO read port and of the output stream
  localparam int DATA_WIDTH = 16;

  // Default frame marker and filler word
  localparam logic [DATA_WIDTH-1:0] HEADER_DEFAULT   = 16'hA5A5;
  localparam logic [DATA_WIDTH-1:0] PAD_WORD_DEFAULT = 16'h0000;

  // FSM state encodings
  localparam logic [2:0] c_st_idle     = 3'd0;
  localparam logic [2:0] c_st_header   = 3'd1;
  localparam logic [2:0] c_st_payload  = 3'd2;
  localparam logic [2:0] c_st_pad      = 3'd3;
  localparam logic [2:0] c_st_checksum = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = c_st_idle,
    S_HEADER   = c_st_header,
    S_PAYLOAD  = c_st_payload,
    S_PAD      = c_st_pad,
    S_CHECKSUM = c_st_checksum
  } state_t;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : stream_out_reg
// Description : Single-entry valid/ready output register. Holds data/last
//               stable while valid is high and not yet accepted, and reports
//               when a new word may be loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_out_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_slot_free
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;

  // Slot can take a new word if empty or its current word leaves this edge
  assign o_slot_free = ~r_valid | i_ready;

  // Load a new word, or drop valid once the held word has been accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;

endmodule : stream_out_reg
`default_nettype wire

// File: rtl/fifo_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_frame_reader
// Description : Drains 16-bit words from the async FIFO read side and emits
//               framed packets (HEADER, payload, additive checksum) on a
//               valid/ready stream; pads partial frames after an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_frame_reader #(
  parameter int                                DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int                                FRAME_LEN  = 4,
  parameter logic [fifo_pkg::DATA_WIDTH-1:0]   HEADER     = fifo_pkg::HEADER_DEFAULT,
  parameter logic [fifo_pkg::DATA_WIDTH-1:0]   PAD_WORD   = fifo_pkg::PAD_WORD_DEFAULT,
  parameter int                                TIMEOUT    = 8
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [15:0]           frame_count,
  output logic                  busy
);

  import fifo_pkg::*;

  localparam logic [7:0]  c_frame_len = 8'(FRAME_LEN);
  localparam logic [15:0] c_timeout   = 16'(TIMEOUT);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_sum;
  logic [7:0]            r_cnt;
  logic [15:0]           r_tmo;
  logic [15:0]           r_frame_count;

  logic                  w_slot_free;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic                  w_load_last;
  logic                  w_pop;
  logic                  w_add;
  logic                  w_tmo_inc;
  logic                  w_clr_frame;
  logic                  w_frame_done;
  logic [7:0]            w_cnt_inc;
  logic [15:0]           w_tmo_inc_val;
  logic                  w_last_word;

  assign w_cnt_inc     = r_cnt + 8'd1;
  assign w_tmo_inc_val = r_tmo + 16'd1;
  assign w_last_word   = (w_cnt_inc == c_frame_len);

  // State register
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and slot/pop/counter control; the timeout is taken on the
  // increment that reaches TIMEOUT, so words arriving afterwards are never
  // popped into a frame that is already padding
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_load_data  = '0;
    w_load_last  = 1'b0;
    w_pop        = 1'b0;
    w_add        = 1'b0;
    w_tmo_inc    = 1'b0;
    w_clr_frame  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty) w_state_nxt = S_HEADER;
      end
      S_HEADER: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = HEADER;
          w_clr_frame = 1'b1;
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (!fifo_empty && w_slot_free) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_load_data = fifo_data;
          w_add       = 1'b1;
          if (w_last_word) w_state_nxt = S_CHECKSUM;
        end else if (fifo_empty && w_slot_free && (c_timeout != 16'd0)
                     && (r_tmo != c_timeout)) begin
          w_tmo_inc = 1'b1;
          if (w_tmo_inc_val == c_timeout) w_state_nxt = S_PAD;
        end
      end
      S_PAD: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_data = PAD_WORD;
          w_add       = 1'b1;
          if (w_last_word) w_state_nxt = S_CHECKSUM;
        end
      end
      S_CHECKSUM: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_data  = r_sum;
          w_load_last  = 1'b1;
          w_frame_done = 1'b1;
          w_state_nxt  = fifo_empty ? S_IDLE : S_HEADER;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Checksum, word counter, idle-timeout counter and completed-frame counter
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      r_sum         <= '0;
      r_cnt         <= 8'd0;
      r_tmo         <= 16'd0;
      r_frame_count <= 16'd0;
    end else begin
      if (w_clr_frame) begin
        r_sum <= '0;
        r_cnt <= 8'd0;
        r_tmo <= 16'd0;
      end else begin
        if (w_add) begin
          r_sum <= r_sum + w_load_data;
          r_cnt <= w_cnt_inc;
        end
        if (w_pop) begin
          r_tmo <= 16'd0;
        end else if (w_tmo_inc) begin
          r_tmo <= w_tmo_inc_val;
        end
      end
      if (w_frame_done) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  stream_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_stream_out_reg (
    .clk         (rd_clk),
    .rst         (reset),
    .i_load      (w_load),
    .i_data      (w_load_data),
    .i_last      (w_load_last),
    .i_ready     (m_ready),
    .o_data      (m_data),
    .o_valid     (m_valid),
    .o_last      (m_last),
    .o_slot_free (w_slot_free)
  );

  assign rd_en       = w_pop & ~reset;
  assign frame_count = r_frame_count;
  assign busy        = (r_state != S_IDLE);

endmodule : fifo_frame_reader
`default_nettype wire

// File: tb/tb_fifo_frame_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_frame_reader
// Description : Directed self-checking bench for fifo_frame_reader with a
//               queue-based FIFO model and an expected-word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_frame_reader;

  logic        rd_clk = 1'b0;
  logic        reset  = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_data  = 16'h0;
  logic        rd_en;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic [15:0] frame_count;
  logic        busy;

  logic [15:0] fifo_q[$];
  logic [16:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_run = 0, rd_max = 0, rd_total = 0;
  int n_beats = 0, first_beat = 0, last_beat = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_frame_reader #(
    .DATA_WIDTH (16),
    .FRAME_LEN  (4),
    .HEADER     (16'hA5A5),
    .PAD_WORD   (16'h0000),
    .TIMEOUT    (8)
  ) dut (
    .rd_clk      (rd_clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .rd_en       (rd_en),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .frame_count (frame_count),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 16'h0 : fifo_q[0];
  endtask

  task automatic push_word(input logic [15:0] w);
    fifo_q.push_back(w);
    fifo_sync();
  endtask

  // Expected frame: header, four payload words, 16-bit wrapping sum with last
  task automatic exp_frame(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
    logic [15:0] s;
    s = a + b + c + d;
    exp_q.push_back({1'b0, 16'hA5A5});
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b0, b});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({1'b0, d});
    exp_q.push_back({1'b1, s});
  endtask

  task automatic reset_stats();
    rd_run = 0; rd_max = 0; rd_total = 0;
    n_beats = 0; first_beat = 0; last_beat = 0;
  endtask

  // One clock: sample before the edge, score beats, then model the FIFO pop
  task automatic tick();
    logic        s_rd, s_beat, s_last;
    logic [15:0] s_data;
    logic [16:0] e;
    #1;
    s_rd   = rd_en;
    s_beat = m_valid & m_ready & ~reset;
    s_data = m_data;
    s_last = m_last;
    check("rd_en_while_empty", {31'b0, rd_en & fifo_empty}, 32'd0);
    if (s_beat) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", {16'b0, s_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", {16'b0, s_data}, {16'b0, e[15:0]});
        check("sb_last", {31'b0, s_last}, {31'b0, e[16]});
      end
      if (n_beats == 0) first_beat = cyc;
      last_beat = cyc;
      n_beats++;
    end
    if (s_rd) begin
      rd_run++; rd_total++;
      if (rd_run > rd_max) rd_max = rd_run;
    end else begin
      rd_run = 0;
    end
    @(posedge rd_clk);
    #1;
    cyc++;
    if (s_rd && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
    end
    fifo_sync();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((busy || m_valid || fifo_q.size() != 0 || exp_q.size() != 0) && k < 100) begin
      tick();
      k++;
    end
    check(tag, {31'b0, (k < 100)}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state
    reset = 1'b1;
    m_ready = 1'b1;
    fifo_sync();
    tick();
    tick();
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_last", {31'b0, m_last}, 32'd0);
    check("rst_m_data", {16'b0, m_data}, 32'd0);
    check("rst_frame_count", {16'b0, frame_count}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rd_en", {31'b0, rd_en}, 32'd0);
    reset = 1'b0;

    // 1: basic frame, one pop per cycle
    reset_stats();
    push_word(16'h0001); push_word(16'h0002); push_word(16'h0003); push_word(16'h0004);
    exp_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    drain("t1_drain");
    check("t1_rd_total", rd_total, 32'd4);
    check("t1_rd_consecutive", rd_max, 32'd4);
    check("t1_frame_count", {16'b0, frame_count}, 32'd1);

    // 2: downstream stall while 0002 is presented
    push_word(16'h0001); push_word(16'h0002); push_word(16'h0003); push_word(16'h0004);
    exp_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    k = 0;
    while (!(m_valid && m_data == 16'h0002) && k < 20) begin
      tick();
      k++;
    end
    check("t2_found_0002", {31'b0, (k < 20)}, 32'd1);
    m_ready = 1'b0;
    repeat (3) begin
      #1;
      check("t2_hold_data", {16'b0, m_data}, 32'h0002);
      check("t2_hold_valid", {31'b0, m_valid}, 32'd1);
      check("t2_hold_rd_en", {31'b0, rd_en}, 32'd0);
      tick();
    end
    m_ready = 1'b1;
    drain("t2_drain");
    check("t2_frame_count", {16'b0, frame_count}, 32'd2);

    // 3: partial frame padded after timeout
    push_word(16'h0010); push_word(16'h0020);
    exp_frame(16'h0010, 16'h0020, 16'h0000, 16'h0000);
    drain("t3_drain");
    check("t3_busy", {31'b0, busy}, 32'd0);
    check("t3_frame_count", {16'b0, frame_count}, 32'd3);

    // 4: checksum carry discarded
    push_word(16'hFFFF); push_word(16'h0002); push_word(16'h0000); push_word(16'h0000);
    exp_frame(16'hFFFF, 16'h0002, 16'h0000, 16'h0000);
    drain("t4_drain");
    check("t4_frame_count", {16'b0, frame_count}, 32'd4);

    // 5: two back-to-back frames without a bubble
    reset_stats();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    exp_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    exp_frame(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    drain("t5_drain");
    check("t5_beats", n_beats, 32'd12);
    check("t5_contiguous", last_beat - first_beat + 1, 32'd12);
    check("t5_frame_count", {16'b0, frame_count}, 32'd6);

    // 6: reset right after the header is accepted
    push_word(16'h0001); push_word(16'h0002); push_word(16'h0003); push_word(16'h0004);
    exp_q.push_back({1'b0, 16'hA5A5});
    k = 0;
    while (!(m_valid && m_data == 16'hA5A5) && k < 20) begin
      tick();
      k++;
    end
    check("t6_found_header", {31'b0, (k < 20)}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_m_valid", {31'b0, m_valid}, 32'd0);
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_frame_count", {16'b0, frame_count}, 32'd0);
    check("t6_rd_en", {31'b0, rd_en}, 32'd0);
    exp_frame(16'h0002, 16'h0003, 16'h0004, 16'h0000);
    drain("t6_drain");
    check("t6_frame_count_after", {16'b0, frame_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo_frame_reader
`default_nettype wire
